// File: rtl/xbus_interconnect_if.sv
// XBUS bundle between the core, xbus_interconnect and its slave ports.
// "slave" is the interconnect's view; "master" is the core/slave-model view.
interface xbus_interconnect_if #(
    parameter int unsigned NSLAVES = 4
) ();
    logic                    xbus_as;
    logic [31:0]             xbus_addr;
    logic [31:0]             xbus_rdata;
    logic                    xbus_rdy;
    logic                    xbus_err;
    logic [NSLAVES-1:0]      xbus_cs;
    logic [NSLAVES*32-1:0]   slv_rdata;
    logic [NSLAVES-1:0]      slv_rdy;

    modport slave (
        input  xbus_as, xbus_addr, slv_rdata, slv_rdy,
        output xbus_rdata, xbus_rdy, xbus_err, xbus_cs
    );

    modport master (
        output xbus_as, xbus_addr, slv_rdata, slv_rdy,
        input  xbus_rdata, xbus_rdy, xbus_err, xbus_cs
    );
endinterface

// File: rtl/xbus_interconnect.sv
// XBUS interconnect: base/mask decode, wait-state handshake, timeout watchdog, error response.
// Optional sticky error log is built when XBUS_ERRLOG_EN is defined.
module xbus_interconnect #(
    parameter int unsigned            NSLAVES = 4,
    parameter logic [32*NSLAVES-1:0]  BASE    = {32'h4000_0000, 32'h3000_0000,
                                                 32'h2000_0000, 32'h0000_0000},
    parameter logic [32*NSLAVES-1:0]  MASK    = {32'hF000_0000, 32'hF000_0000,
                                                 32'hF000_0000, 32'hFFFF_0000},
    parameter int unsigned            TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    xbus_interconnect_if.slave  bus,
    output logic                err_valid,
    output logic [1:0]          err_cause,
    output logic [31:0]         err_addr,
    input  logic                err_clr
);

    localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    logic [1:0]         state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
    logic [SW-1:0]      sel_q, sel_nxt, sel_cur, dec_idx;
    logic [1:0]         cause_q, cause_nxt;
    logic               hit;
    logic               cs_en;
    logic               rdy_c;
    logic               err_c;
    logic               sel_rdy;
    logic [31:0]        sel_rdata;
    logic [NSLAVES-1:0] cs_c;

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        dec_idx = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((bus.xbus_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
                hit     = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    // In WAIT the latched index is used so the address is never re-decoded.
    assign sel_cur = (state == S_WAIT) ? sel_q : dec_idx;

    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        cs_c      = '0;
        for (int i = 0; i < int'(NSLAVES); i++) begin
            if (sel_cur == SW'(i)) begin
                sel_rdy   = bus.slv_rdy[i];
                sel_rdata = bus.slv_rdata[32*i +: 32];
                cs_c[i]   = cs_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            cause_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel_q   <= sel_nxt;
            cause_q <= cause_nxt;
        end
    end

    // Next state and bus response.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        cause_nxt = cause_q;
        cs_en     = 1'b0;
        rdy_c     = 1'b0;
        err_c     = 1'b0;
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

        case (state)
            S_IDLE: begin
                if (bus.xbus_as) begin
                    if (hit) begin
                        cs_en   = 1'b1;
                        sel_nxt = dec_idx;
                        if (sel_rdy) begin
                            rdy_c = 1'b1;
                        end else if (CNT_MAX == CW'(1)) begin
                            state_nxt = S_ERR;
                            cause_nxt = CAUSE_TIMEOUT;
                        end else begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = CW'(1);
                        end
                    end else begin
                        state_nxt = S_ERR;
                        cause_nxt = CAUSE_UNMAPPED;
                    end
                end
            end
            S_WAIT: begin
                // Chip select drops with an abort so an abandoned write can never commit.
                if (!bus.xbus_as) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cs_en = 1'b1;
                    if (sel_rdy) begin
                        rdy_c     = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_nxt = S_ERR;
                            cause_nxt = CAUSE_TIMEOUT;
                        end
                    end
                end
            end
            S_ERR: begin
                rdy_c     = 1'b1;
                err_c     = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.xbus_cs    = rst ? '0 : cs_c;
    assign bus.xbus_rdy   = ~rst & rdy_c;
    assign bus.xbus_err   = ~rst & err_c;
    assign bus.xbus_rdata = (rst || !rdy_c || err_c) ? 32'd0 : sel_rdata;

`ifdef XBUS_ERRLOG_EN
    // First error is held; a clear in the same cycle as an error yields to the new entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_cause <= '0;
            err_addr  <= '0;
        end else if ((state == S_ERR) && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_cause <= cause_q;
            err_addr  <= bus.xbus_addr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_cause <= '0;
            err_addr  <= '0;
        end
    end
`else
    logic errlog_unused;
    assign errlog_unused = ^{err_clr, cause_q};
    assign err_valid = 1'b0;
    assign err_cause = '0;
    assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_xbus_interconnect.sv
// Scoreboard bench for xbus_interconnect: directed plan cases plus randomized traffic
// checked against a transaction-level model of decode, latency and error logging.
module tb_xbus_interconnect;
    localparam int unsigned NS   = 4;
    localparam int unsigned TO   = 16;
    localparam int          HUNG = 999;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic        err_valid;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    xbus_interconnect_if #(.NSLAVES(NS)) bus ();

    xbus_interconnect #(.NSLAVES(NS), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_valid (err_valid),
        .err_cause (err_cause),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [31:0]   rdata;
        int            lat;
        int            cs_cycles;
        logic [NS-1:0] cs_at_rdy;
        logic          lv;
        logic [1:0]    lc;
        logic [31:0]   la;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    exp_t        pend;
    int          tests = 0;
    int          fails = 0;
    int          req_cyc = 0;
    int          cs_cyc = 0;
    bit          chk_log = 1'b0;
    logic        m_lv = 1'b0;
    logic [1:0]  m_lc = 2'b00;
    logic [31:0] m_la = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Default address map: slave0 0x0000_xxxx, slave1 0x2xxx_xxxx, slave2 0x3..., slave3 0x4...
    function automatic int ref_decode(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        case (a[31:28])
            4'h2:    return 1;
            4'h3:    return 2;
            4'h4:    return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mapped_addr(input int s);
        logic [31:0] r;
        r = $urandom;
        if (s == 0) return {16'h0000, r[15:0]};
        return {4'(s + 1), r[27:0]};
    endfunction

    function automatic logic [31:0] unmapped_addr();
        logic [31:0] r;
        do r = $urandom; while (ref_decode(r) >= 0);
        return r;
    endfunction

    task automatic model_err(input logic [1:0] cause, input logic [31:0] a, input bit clr_same);
        if (!m_lv || clr_same) begin
            m_lv = 1'b1;
            m_lc = cause;
            m_la = a;
        end
`ifndef XBUS_ERRLOG_EN
        m_lv = 1'b0;
        m_lc = 2'b00;
        m_la = 32'd0;
`endif
    endtask

    task automatic model_clr();
        m_lv = 1'b0;
        m_lc = 2'b00;
        m_la = 32'd0;
    endtask

    // Monitor: pops the scoreboard on every completed transfer.
    always @(negedge clk) begin
        if (chk_log) begin
            chk_log = 1'b0;
            check("err_valid", 32'(err_valid), 32'(pend.lv));
            check("err_cause", 32'(err_cause), 32'(pend.lc));
            check("err_addr",  err_addr,       pend.la);
        end
        if (rst) begin
            req_cyc = 0;
            cs_cyc  = 0;
        end else if (bus.xbus_as) begin
            if (bus.xbus_cs != '0) cs_cyc++;
            if (bus.xbus_rdy) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rdy @%0t: got rdy=1, want no response", $time);
                end else begin
                    cur = sb.pop_front();
                    check("xbus_err",   32'(bus.xbus_err), 32'(cur.err));
                    check("xbus_rdata", bus.xbus_rdata,    cur.rdata);
                    check("latency",    32'(req_cyc),      32'(cur.lat));
                    check("cs_cycles",  32'(cs_cyc),       32'(cur.cs_cycles));
                    check("cs_at_rdy",  32'(bus.xbus_cs),  32'(cur.cs_at_rdy));
                    pend    = cur;
                    chk_log = 1'b1;
                end
                req_cyc = 0;
                cs_cyc  = 0;
            end else begin
                req_cyc++;
            end
        end else begin
            check("rdy_without_as", 32'(bus.xbus_rdy), 32'd0);
            req_cyc = 0;
            cs_cyc  = 0;
        end
    end

    // One master request; the target slave raises ready after w wait states.
    task automatic run_txn(input logic [31:0] addr, input int w, input int abort_at,
                           input bit clr_same, input int gap);
        logic [NS*32-1:0] rd;
        exp_t             e;
        int               tgt;
        int               err_cyc;
        int               c;
        bit               done;
        for (int i = 0; i < int'(NS); i++) rd[32*i +: 32] = $urandom;
        bus.slv_rdata = rd;
        tgt     = ref_decode(addr);
        err_cyc = -1;
        e.err = 1'b0; e.rdata = 32'd0; e.lat = 0; e.cs_cycles = 0; e.cs_at_rdy = '0;
        if (abort_at < 0) begin
            if (tgt < 0) begin
                e.err = 1'b1; e.lat = 1; err_cyc = 1;
                model_err(2'b01, addr, clr_same);
            end else if (w >= int'(TO)) begin
                e.err = 1'b1; e.lat = int'(TO); e.cs_cycles = int'(TO); err_cyc = int'(TO);
                model_err(2'b10, addr, clr_same);
            end else begin
                e.rdata = rd[32*tgt +: 32];
                e.lat = w;
                e.cs_cycles = w + 1;
                e.cs_at_rdy[tgt] = 1'b1;
            end
            e.lv = m_lv; e.lc = m_lc; e.la = m_la;
            sb.push_back(e);
        end
        c    = 0;
        done = 1'b0;
        while (!done) begin
            bus.xbus_addr = addr;
            bus.xbus_as   = (c != abort_at);
            for (int i = 0; i < int'(NS); i++)
                bus.slv_rdy[i] = (i == tgt) ? (c >= w) : 1'($urandom_range(0, 1));
            err_clr = clr_same && (c == err_cyc);
            @(negedge clk);
            if (c == abort_at || bus.xbus_rdy) begin
                done = 1'b1;
            end else if (c > int'(TO) + 4) begin
                tests++;
                fails++;
                $display("FAIL no_response addr=0x%08h: got no rdy after %0d cycles, want rdy", addr, c);
                done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.xbus_as  = 1'b0;
        bus.slv_rdy  = '0;
        err_clr      = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        model_clr();
        @(negedge clk);
        check("clr_valid", 32'(err_valid), 32'(m_lv));
        check("clr_cause", 32'(err_cause), 32'(m_lc));
        check("clr_addr",  err_addr,       m_la);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.xbus_as   = 1'b0;
        bus.xbus_addr = 32'd0;
        bus.slv_rdy   = '0;
        bus.slv_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.xbus_as   = 1'b1;
        bus.xbus_addr = 32'h2000_0000;
        bus.slv_rdy   = '1;
        @(negedge clk);
        check("rst_cs",    32'(bus.xbus_cs),  32'd0);
        check("rst_rdy",   32'(bus.xbus_rdy), 32'd0);
        check("rst_err",   32'(bus.xbus_err), 32'd0);
        check("rst_rdata", bus.xbus_rdata,    32'd0);
        check("rst_log",   {err_valid, err_cause, err_addr[28:0]}, 32'd0);
        @(posedge clk); #1;
        bus.xbus_as = 1'b0;
        bus.slv_rdy = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(32'h2000_0010, 0, -1, 1'b0, 1);      // zero-wait slave 1
        run_txn(32'h3000_0100, 3, -1, 1'b0, 1);      // slave 2, three wait states
        run_txn(32'h5000_0000, 0, -1, 1'b0, 1);      // unmapped
        do_clr();
        run_txn(32'h0000_0004, HUNG, -1, 1'b0, 0);   // slave 0 hung -> timeout logged
        run_txn(32'h0000_0008, HUNG, -1, 1'b0, 1);   // second error not logged
        do_clr();
        run_txn(32'h4000_0020, HUNG, 2, 1'b0, 1);    // abort in WAIT cycle 2
        run_txn(32'h4000_0024, 1, -1, 1'b0, 1);
        run_txn(32'h0000_0010, int'(TO) - 1, -1, 1'b0, 1);  // last cycle before timeout

        // Reset in the middle of a wait-state transfer.
        bus.slv_rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        bus.xbus_addr = 32'h3000_0040;
        bus.xbus_as   = 1'b1;
        bus.slv_rdy   = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.slv_rdy = '1;
        @(posedge clk); #1;
        model_clr();
        @(negedge clk);
        check("wrst_cs",    32'(bus.xbus_cs),  32'd0);
        check("wrst_rdy",   32'(bus.xbus_rdy), 32'd0);
        check("wrst_rdata", bus.xbus_rdata,    32'd0);
        check("wrst_log",   32'(err_valid),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(32'h2000_0000, 0, -1, 1'b0, 0);      // first cycle after reset, back-to-back
        run_txn(32'h3000_0000, 2, -1, 1'b0, 0);
        run_txn(32'h8000_0000, 0, -1, 1'b0, 0);      // unmapped, back-to-back after ERR
        run_txn(32'h0000_1000, HUNG, -1, 1'b1, 1);   // clear coincides with new error

        for (int n = 0; n < 300; n++) begin
            int          r;
            int          gap;
            logic [31:0] a;
            r   = int'($urandom_range(0, 11));
            gap = int'($urandom_range(0, 2));
            a   = mapped_addr(int'($urandom_range(0, NS - 1)));
            case (r)
                0:       run_txn(unmapped_addr(), 0, -1, 1'($urandom_range(0, 1)), gap);
                1:       run_txn(a, HUNG, -1, 1'($urandom_range(0, 1)), gap);
                2:       run_txn(a, HUNG, int'($urandom_range(1, TO - 1)), 1'b0, gap);
                3:       do_clr();
                4:       run_txn(a, int'($urandom_range(6, TO - 1)), -1, 1'b0, gap);
                default: run_txn(a, int'($urandom_range(0, 5)), -1, 1'b0, gap);
            endcase
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
